// File: rtl/cdb_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : cdb_arbiter
//  Brief    : Completion-bus arbiter. Each functional unit owns a one-entry
//             holding register. Every cycle up to N_CDB occupied holds are
//             granted in round-robin order and broadcast on registered CDB
//             slots. A branch squash flushes all in-flight results.
//  Revision : 1.0  initial release
// ============================================================================
module cdb_arbiter #(
  parameter int N_FU     = 4,
  parameter int N_CDB    = 2,
  parameter int CDB_BITS = 6,
  parameter int XLEN     = 32,
  localparam int SRC_W   = (N_FU > 1) ? $clog2(N_FU) : 1
) (
  input  logic                               i_clock,
  input  logic                               i_reset,
  input  logic [N_FU-1:0]                    i_fu_valid,
  input  logic [N_FU-1:0][CDB_BITS-1:0]      i_fu_tag,
  input  logic [N_FU-1:0][XLEN-1:0]          i_fu_data,
  output logic [N_FU-1:0]                    o_fu_ready,
  input  logic                               i_branch_haz,
  output logic [N_CDB-1:0]                   o_cdb_valid,
  output logic [N_CDB-1:0][CDB_BITS-1:0]     o_cdb_tag,
  output logic [N_CDB-1:0][XLEN-1:0]         o_cdb_data,
  output logic [N_CDB-1:0][SRC_W-1:0]        o_cdb_src
);

  localparam int CNT_W = (N_CDB > 1) ? $clog2(N_CDB) : 1;

  // Holding registers, one per functional unit
  logic [N_FU-1:0]                r_hold_v;
  logic [N_FU-1:0][CDB_BITS-1:0]  r_hold_tag;
  logic [N_FU-1:0][XLEN-1:0]      r_hold_data;

  // Round-robin start index for the grant scan
  logic [SRC_W-1:0]               r_rr_ptr;

  // Registered CDB slots
  logic [N_CDB-1:0]               r_cdb_valid;
  logic [N_CDB-1:0][CDB_BITS-1:0] r_cdb_tag;
  logic [N_CDB-1:0][XLEN-1:0]     r_cdb_data;
  logic [N_CDB-1:0][SRC_W-1:0]    r_cdb_src;

  // Grant results
  logic [N_FU-1:0]                w_grant;
  logic [N_CDB-1:0]               w_slot_v;
  logic [N_CDB-1:0][SRC_W-1:0]    w_slot_fu;
  logic [SRC_W-1:0]               w_last;
  logic [SRC_W-1:0]               w_rr_next;
  logic [N_FU-1:0]                w_accept;
  logic                           w_flush;

  // Round-robin scan over the holds: the k-th occupied hold found starting
  // at r_rr_ptr is placed on slot k, until all slots are used.
  always_comb begin
    int               cnt;
    int               idx;
    logic [SRC_W-1:0] idx_w;
    w_grant   = '0;
    w_slot_v  = '0;
    w_slot_fu = '0;
    w_last    = '0;
    cnt       = 0;
    idx       = 0;
    idx_w     = '0;
    for (int k = 0; k < N_FU; k++) begin
      idx = int'(r_rr_ptr) + k;
      if (idx >= N_FU) begin
        idx = idx - N_FU;
      end
      idx_w = SRC_W'(idx);
      if (r_hold_v[idx_w] && (cnt < N_CDB)) begin
        w_grant[idx_w]            = 1'b1;
        w_slot_v[CNT_W'(cnt)]     = 1'b1;
        w_slot_fu[CNT_W'(cnt)]    = idx_w;
        w_last                    = idx_w;
        cnt                       = cnt + 1;
      end
    end
  end

  // Pointer advances past the last granted unit, wrapping at N_FU so that
  // non-power-of-two unit counts never produce an out-of-range index.
  assign w_rr_next = (w_last == SRC_W'(N_FU - 1)) ? '0 : (w_last + SRC_W'(1));

  // A unit can hand over a result when its hold is empty or being drained.
  // Deliberately independent of i_fu_valid to avoid a combinational loop.
  assign w_flush    = i_reset | i_branch_haz;
  assign o_fu_ready = {N_FU{~w_flush}} & (~r_hold_v | w_grant);
  assign w_accept   = i_fu_valid & o_fu_ready;

  // Hold update: flush, load (tag 0 is consumed and dropped), drain on grant
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_hold_v    <= '0;
      r_hold_tag  <= '0;
      r_hold_data <= '0;
    end else begin
      for (int i = 0; i < N_FU; i++) begin
        if (i_branch_haz) begin
          r_hold_v[i] <= 1'b0;
        end else if (w_accept[i]) begin
          r_hold_v[i] <= (i_fu_tag[i] != '0);
          if (i_fu_tag[i] != '0) begin
            r_hold_tag[i]  <= i_fu_tag[i];
            r_hold_data[i] <= i_fu_data[i];
          end
        end else if (w_grant[i]) begin
          r_hold_v[i] <= 1'b0;
        end
      end
    end
  end

  // CDB slot registers: broadcast the granted holds, zero unused slots
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_cdb_valid <= '0;
      r_cdb_tag   <= '0;
      r_cdb_data  <= '0;
      r_cdb_src   <= '0;
    end else begin
      for (int k = 0; k < N_CDB; k++) begin
        if (i_branch_haz || !w_slot_v[k]) begin
          r_cdb_valid[k] <= 1'b0;
          r_cdb_tag[k]   <= '0;
          r_cdb_data[k]  <= '0;
          r_cdb_src[k]   <= '0;
        end else begin
          r_cdb_valid[k] <= 1'b1;
          r_cdb_tag[k]   <= r_hold_tag[w_slot_fu[k]];
          r_cdb_data[k]  <= r_hold_data[w_slot_fu[k]];
          r_cdb_src[k]   <= w_slot_fu[k];
        end
      end
    end
  end

  // Round-robin pointer moves only when something was granted and not squashed
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_rr_ptr <= '0;
    end else if (!i_branch_haz && (|w_grant)) begin
      r_rr_ptr <= w_rr_next;
    end
  end

  assign o_cdb_valid = r_cdb_valid;
  assign o_cdb_tag   = r_cdb_tag;
  assign o_cdb_data  = r_cdb_data;
  assign o_cdb_src   = r_cdb_src;

endmodule
`default_nettype wire

// File: tb/tb_cdb_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_cdb_arbiter
//  Brief    : Self-checking bench for cdb_arbiter (N_FU=4, N_CDB=2):
//             directed vector table plus reset, latency and fairness sequences.
//  Revision : 1.0  initial release
// ============================================================================
module tb_cdb_arbiter;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [3:0]           fu_valid;
  logic [3:0][5:0]      fu_tag;
  logic [3:0][31:0]     fu_data;
  logic [3:0]           fu_ready;
  logic                 haz;
  logic [1:0]           cdb_valid;
  logic [1:0][5:0]      cdb_tag;
  logic [1:0][31:0]     cdb_data;
  logic [1:0][1:0]      cdb_src;

  int n_chk  = 0;
  int n_pass = 0;

  typedef struct {
    logic [3:0]  v;    // fu_valid
    logic [23:0] t;    // fu_tag {fu3,fu2,fu1,fu0}
    logic        h;    // branch_haz
    logic [3:0]  er;   // expected fu_ready
    logic [1:0]  ecv;  // expected cdb_valid
    logic [11:0] et;   // expected cdb_tag {slot1,slot0}
    logic [3:0]  es;   // expected cdb_src {slot1,slot0}
    logic [1:0]  err;  // expected rr_ptr
  } vec_t;

  vec_t tbl[22];

  cdb_arbiter #(.N_FU(4), .N_CDB(2), .CDB_BITS(6), .XLEN(32)) dut (
    .i_clock      (clk),
    .i_reset      (rst),
    .i_fu_valid   (fu_valid),
    .i_fu_tag     (fu_tag),
    .i_fu_data    (fu_data),
    .o_fu_ready   (fu_ready),
    .i_branch_haz (haz),
    .o_cdb_valid  (cdb_valid),
    .o_cdb_tag    (cdb_tag),
    .o_cdb_data   (cdb_data),
    .o_cdb_src    (cdb_src)
  );

  always #5 clk = ~clk;

  // Result value a unit drives for a given tag
  function automatic logic [31:0] dfn(input logic [1:0] fu, input logic [5:0] tag);
    return 32'h5A00_00AA | (32'(fu) << 20) | (32'(tag) << 8);
  endfunction

  function automatic vec_t mk(input logic [3:0] v, input logic [23:0] t, input logic h,
                              input logic [3:0] er, input logic [1:0] ecv,
                              input logic [11:0] et, input logic [3:0] es,
                              input logic [1:0] err);
    vec_t r;
    r.v = v; r.t = t; r.h = h; r.er = er; r.ecv = ecv; r.et = et; r.es = es; r.err = err;
    return r;
  endfunction

  task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  task automatic check_cdb(input string nm, input logic [1:0] ev,
                           input logic [11:0] et, input logic [3:0] es);
    logic [1:0][5:0]  etp;
    logic [1:0][1:0]  esp;
    logic [1:0][31:0] edp;
    etp = et;
    esp = es;
    for (int k = 0; k < 2; k++) begin
      if (!ev[k]) begin
        etp[k] = '0;
        esp[k] = '0;
      end
      edp[k] = ev[k] ? dfn(esp[k], etp[k]) : 32'h0;
    end
    check({nm, "_valid"}, 128'(cdb_valid), 128'(ev));
    check({nm, "_tag"},   128'(cdb_tag),   128'(etp));
    check({nm, "_src"},   128'(cdb_src),   128'(esp));
    check({nm, "_data"},  128'(cdb_data),  128'(edp));
  endtask

  task automatic drive(input logic [3:0] v, input logic [23:0] t, input logic h);
    fu_valid = v;
    fu_tag   = t;
    for (int i = 0; i < 4; i++) fu_data[i] = dfn(2'(i), fu_tag[i]);
    haz = h;
  endtask

  initial begin
    logic [5:0]  mh[4];
    int          acc_dut[4];
    int          acc_mod[4];
    logic [3:0]  er;
    logic [1:0]  ecv;
    logic [11:0] et;
    logic [3:0]  es;
    logic [23:0] tv;

    // contention from rr=0
    tbl[0]  = mk(4'b1111, {6'd4,6'd3,6'd2,6'd1}, 1'b0, 4'b1111, 2'b00, 12'd0, 4'd0, 2'd0);
    tbl[1]  = mk(4'b0000, 24'd0, 1'b0, 4'b0011, 2'b00, 12'd0, 4'd0, 2'd0);
    tbl[2]  = mk(4'b0000, 24'd0, 1'b0, 4'b1111, 2'b11, {6'd2,6'd1}, {2'd1,2'd0}, 2'd2);
    tbl[3]  = mk(4'b0000, 24'd0, 1'b0, 4'b1111, 2'b11, {6'd4,6'd3}, {2'd3,2'd2}, 2'd0);
    tbl[4]  = mk(4'b0000, 24'd0, 1'b0, 4'b1111, 2'b00, 12'd0, 4'd0, 2'd0);
    // single result FU1 tag 5
    tbl[5]  = mk(4'b0010, {6'd0,6'd0,6'd5,6'd0}, 1'b0, 4'b1111, 2'b00, 12'd0, 4'd0, 2'd0);
    tbl[6]  = mk(4'b0000, 24'd0, 1'b0, 4'b1111, 2'b00, 12'd0, 4'd0, 2'd0);
    tbl[7]  = mk(4'b0000, 24'd0, 1'b0, 4'b1111, 2'b01, {6'd0,6'd5}, {2'd0,2'd1}, 2'd2);
    tbl[8]  = mk(4'b0000, 24'd0, 1'b0, 4'b1111, 2'b00, 12'd0, 4'd0, 2'd2);
    // tag-0 drop on FU2 alongside a real result on FU3
    tbl[9]  = mk(4'b1100, {6'd7,6'd0,6'd0,6'd0}, 1'b0, 4'b1111, 2'b00, 12'd0, 4'd0, 2'd2);
    tbl[10] = mk(4'b0000, 24'd0, 1'b0, 4'b1111, 2'b00, 12'd0, 4'd0, 2'd2);
    tbl[11] = mk(4'b0000, 24'd0, 1'b0, 4'b1111, 2'b01, {6'd0,6'd7}, {2'd0,2'd3}, 2'd0);
    // back-to-back results on FU0: grant and reload in the same cycle
    tbl[12] = mk(4'b0001, {6'd0,6'd0,6'd0,6'd8}, 1'b0, 4'b1111, 2'b00, 12'd0, 4'd0, 2'd0);
    tbl[13] = mk(4'b0001, {6'd0,6'd0,6'd0,6'd9}, 1'b0, 4'b1111, 2'b00, 12'd0, 4'd0, 2'd0);
    tbl[14] = mk(4'b0000, 24'd0, 1'b0, 4'b1111, 2'b01, {6'd0,6'd8}, {2'd0,2'd0}, 2'd1);
    tbl[15] = mk(4'b0000, 24'd0, 1'b0, 4'b1111, 2'b01, {6'd0,6'd9}, {2'd0,2'd0}, 2'd1);
    tbl[16] = mk(4'b0000, 24'd0, 1'b0, 4'b1111, 2'b00, 12'd0, 4'd0, 2'd1);
    // squash with all holds occupied, then squash against a valid result
    tbl[17] = mk(4'b1111, {6'd13,6'd12,6'd11,6'd10}, 1'b0, 4'b1111, 2'b00, 12'd0, 4'd0, 2'd1);
    tbl[18] = mk(4'b0000, 24'd0, 1'b1, 4'b0000, 2'b00, 12'd0, 4'd0, 2'd1);
    tbl[19] = mk(4'b0001, {6'd0,6'd0,6'd0,6'd14}, 1'b1, 4'b0000, 2'b00, 12'd0, 4'd0, 2'd1);
    tbl[20] = mk(4'b0000, 24'd0, 1'b0, 4'b1111, 2'b00, 12'd0, 4'd0, 2'd1);
    tbl[21] = mk(4'b0000, 24'd0, 1'b0, 4'b1111, 2'b00, 12'd0, 4'd0, 2'd1);

    rst = 1'b1;
    drive(4'b0000, 24'd0, 1'b0);
    #1;
    check("in_reset_ready", 128'(fu_ready), 128'(4'b0000));
    check_cdb("in_reset", 2'b00, 12'd0, 4'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Directed vector table
    for (int i = 0; i < 22; i++) begin
      @(negedge clk);
      drive(tbl[i].v, tbl[i].t, tbl[i].h);
      #1;
      check($sformatf("v%0d_ready", i), 128'(fu_ready), 128'(tbl[i].er));
      check_cdb($sformatf("v%0d", i), tbl[i].ecv, tbl[i].et, tbl[i].es);
      check($sformatf("v%0d_rr", i), 128'(dut.r_rr_ptr), 128'(tbl[i].err));
    end

    // Asynchronous reset raised between edges while both slots are valid
    @(negedge clk);
    drive(4'b0011, {6'd0,6'd0,6'd2,6'd1}, 1'b0);
    @(negedge clk);
    drive(4'b0000, 24'd0, 1'b0);
    @(negedge clk);
    #1;
    check_cdb("pre_rst", 2'b11, {6'd1,6'd2}, {2'd0,2'd1});
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_ready", 128'(fu_ready), 128'(4'b0000));
    check_cdb("async_rst", 2'b00, 12'd0, 4'd0);
    check("async_rst_rr", 128'(dut.r_rr_ptr), 128'(2'd0));
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("post_rst_ready", 128'(fu_ready), 128'(4'b1111));
    @(negedge clk);
    drive(4'b0100, {6'd0,6'd6,6'd0,6'd0}, 1'b0);
    @(negedge clk);
    drive(4'b0000, 24'd0, 1'b0);
    #1;
    check_cdb("post_rst_lat1", 2'b00, 12'd0, 4'd0);
    @(negedge clk);
    #1;
    check_cdb("post_rst_lat2", 2'b01, {6'd0,6'd6}, {2'd0,2'd2});

    // Sustained fairness: all units always valid, fresh tags every cycle
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      mh[i] = '0;
      acc_dut[i] = 0;
      acc_mod[i] = 0;
    end
    ecv = 2'b00;
    et  = '0;
    es  = '0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      for (int i = 0; i < 4; i++) tv[i*6 +: 6] = 6'(((c * 4 + i) % 62) + 1);
      drive(4'b1111, tv, 1'b0);
      #1;
      er = (c == 0) ? 4'b1111 : ((c % 2 == 1) ? 4'b0011 : 4'b1100);
      check($sformatf("fair%0d_ready", c), 128'(fu_ready), 128'(er));
      check($sformatf("fair%0d_cdb", c), 128'({cdb_valid, cdb_src, cdb_tag}),
            128'({ecv, es, et}));
      if (c >= 1) begin
        ecv = 2'b11;
        if (c % 2 == 1) begin
          et = {mh[1], mh[0]};
          es = {2'd1, 2'd0};
        end else begin
          et = {mh[3], mh[2]};
          es = {2'd3, 2'd2};
        end
      end
      for (int i = 0; i < 4; i++) begin
        if (er[i]) begin
          mh[i] = tv[i*6 +: 6];
          acc_mod[i]++;
        end
        if (fu_ready[i]) acc_dut[i]++;
      end
    end
    for (int i = 0; i < 4; i++) begin
      check($sformatf("fair_accepts_fu%0d", i), 128'(acc_dut[i]), 128'(acc_mod[i]));
    end

    @(negedge clk);
    drive(4'b0000, 24'd0, 1'b0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
